// File: rtl/gray_monitor_pkg.sv
// Shared types for the Gray-code monitor: FSM state encoding, error codes and
// reference helpers for the default 3-bit code width.
package gray_mon_pkg;

    localparam int GRAY_W = 3;

    typedef enum logic [1:0] {
        ST_INIT  = 2'b00,
        ST_TRACK = 2'b01,
        ST_ERROR = 2'b10
    } state_t;

    localparam logic [1:0] ERR_NONE   = 2'b00;
    localparam logic [1:0] ERR_MULTI  = 2'b01;
    localparam logic [1:0] ERR_SINGLE = 2'b10;
    localparam logic [1:0] ERR_OV     = 2'b11;

    function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] g);
        logic [GRAY_W-1:0] b;
        b[GRAY_W-1] = g[GRAY_W-1];
        for (int i = GRAY_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic int unsigned popcount(input logic [GRAY_W-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < GRAY_W; i++) begin
            n += int'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/gray_monitor_if.sv
// Monitor bus: Gray/overflow samples in, decoded value and status out.
// Optional Wrap pulse exists only when GRAY_MON_WRAP_PULSE_EN is defined.
interface gray_monitor_if #(
    parameter int WIDTH      = 3,
    parameter int WRAP_CNT_W = 8
);
    logic [WIDTH-1:0]      GrayIn;
    logic                  OverflowIn;
    logic [WIDTH-1:0]      Bin;
    logic                  Step;
    logic [WRAP_CNT_W-1:0] WrapCount;
    logic                  Error;
    logic [1:0]            ErrCode;
    logic [1:0]            State;
`ifdef GRAY_MON_WRAP_PULSE_EN
    logic                  Wrap;
`endif

    modport master (
        output GrayIn, OverflowIn,
        input  Bin, Step, WrapCount, Error, ErrCode, State
`ifdef GRAY_MON_WRAP_PULSE_EN
        , input Wrap
`endif
    );

    modport slave (
        input  GrayIn, OverflowIn,
        output Bin, Step, WrapCount, Error, ErrCode, State
`ifdef GRAY_MON_WRAP_PULSE_EN
        , output Wrap
`endif
    );
endinterface

// File: rtl/gray_monitor_gray_to_bin.sv
// Combinational Gray-to-binary decoder: each binary bit is the XOR of the
// Gray bits at and above its position.
module gray_to_bin #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign bin[gi] = ^gray[WIDTH-1:gi];
        end
    endgenerate
endmodule

// File: rtl/gray_monitor.sv
// Gray counter monitor: decodes each sample and validates hold / +1 / wrap
// transitions plus overflow consistency. Optional Wrap pulse: GRAY_MON_WRAP_PULSE_EN.
module gray_monitor
    import gray_mon_pkg::*;
#(
    parameter int WIDTH      = 3,
    parameter int WRAP_CNT_W = 8
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           Clear,
    gray_monitor_if.slave  mon
);
    logic [WIDTH-1:0]      cur_bin, prev_bin, prev_inc, diff;
    logic [WIDTH-1:0]      bin_q, prev_g_q;
    logic                  prev_ov_q;
    logic                  step_q, step_d;
    logic                  error_q, error_d;
    logic [1:0]            err_code_q, err_code_d, err_sel;
    logic [WRAP_CNT_W-1:0] wrap_cnt_q, wrap_cnt_d;
    state_t                state_q, state_d;
    logic                  one_bit, multi_bit, legal_step, is_wrap, ov_rise, ov_fall, ov_err;
`ifdef GRAY_MON_WRAP_PULSE_EN
    logic                  wrap_q, wrap_d;
`endif

    gray_to_bin #(.WIDTH(WIDTH)) u_cur_bin  (.gray(mon.GrayIn), .bin(cur_bin));
    gray_to_bin #(.WIDTH(WIDTH)) u_prev_bin (.gray(prev_g_q),   .bin(prev_bin));

    always_comb begin
        diff       = mon.GrayIn ^ prev_g_q;
        prev_inc   = prev_bin + WIDTH'(1);
        one_bit    = ($countones(diff) == 1);
        multi_bit  = ($countones(diff) > 1);
        legal_step = one_bit && (cur_bin == prev_inc);
        is_wrap    = legal_step && (&prev_bin);
        ov_rise    = mon.OverflowIn && !prev_ov_q;
        ov_fall    = !mon.OverflowIn && prev_ov_q;
        // Overflow may only rise together with a wrap, and only fall once the count is back at zero.
        ov_err     = (ov_rise && !is_wrap) || (ov_fall && (mon.GrayIn != '0));

        if (multi_bit)                  err_sel = ERR_MULTI;
        else if (one_bit && !legal_step) err_sel = ERR_SINGLE;
        else if (ov_err)                err_sel = ERR_OV;
        else                            err_sel = ERR_NONE;
    end

    always_comb begin
        state_d    = state_q;
        step_d     = 1'b0;
        error_d    = error_q;
        err_code_d = err_code_q;
        wrap_cnt_d = wrap_cnt_q;
`ifdef GRAY_MON_WRAP_PULSE_EN
        wrap_d     = 1'b0;
`endif
        if (Clear) begin
            state_d    = ST_INIT;
            error_d    = 1'b0;
            err_code_d = ERR_NONE;
            wrap_cnt_d = '0;
        end else begin
            case (state_q)
                ST_INIT:  state_d = ST_TRACK;
                ST_TRACK: begin
                    if (err_sel != ERR_NONE) begin
                        state_d    = ST_ERROR;
                        error_d    = 1'b1;
                        err_code_d = err_sel;
                    end else begin
                        step_d = legal_step;
                        if (is_wrap) begin
`ifdef GRAY_MON_WRAP_PULSE_EN
                            wrap_d = 1'b1;
`endif
                            if (!(&wrap_cnt_q)) wrap_cnt_d = wrap_cnt_q + WRAP_CNT_W'(1);
                        end
                    end
                end
                ST_ERROR: state_d = ST_ERROR;
                default:  state_d = ST_INIT;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= ST_INIT;
            bin_q      <= '0;
            prev_g_q   <= '0;
            prev_ov_q  <= 1'b0;
            step_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= ERR_NONE;
            wrap_cnt_q <= '0;
`ifdef GRAY_MON_WRAP_PULSE_EN
            wrap_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            bin_q      <= cur_bin;
            prev_g_q   <= mon.GrayIn;
            prev_ov_q  <= mon.OverflowIn;
            step_q     <= step_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
            wrap_cnt_q <= wrap_cnt_d;
`ifdef GRAY_MON_WRAP_PULSE_EN
            wrap_q     <= wrap_d;
`endif
        end
    end

    assign mon.Bin       = bin_q;
    assign mon.Step      = step_q;
    assign mon.WrapCount = wrap_cnt_q;
    assign mon.Error     = error_q;
    assign mon.ErrCode   = err_code_q;
    assign mon.State     = state_q;
`ifdef GRAY_MON_WRAP_PULSE_EN
    assign mon.Wrap      = wrap_q;
`endif
endmodule

// File: tb/tb_gray_monitor.sv
// Scoreboard bench for gray_monitor: stimulus pushes model expectations,
// a monitor pops and compares one sample per clock edge.
module tb_gray_monitor;
    logic clk = 1'b0;
    logic rst, clr;
    always #5 clk = ~clk;

    gray_monitor_if #(.WIDTH(3), .WRAP_CNT_W(8)) bus ();
    gray_monitor #(.WIDTH(3), .WRAP_CNT_W(8)) dut (
        .Clk(clk), .Reset(rst), .Clear(clr), .mon(bus.slave)
    );

`ifdef GRAY_MON_WRAP_PULSE_EN
    localparam int OW = 18;
`else
    localparam int OW = 17;
`endif

    typedef struct {
        logic [OW-1:0] v;
        string         tag;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    // Reference model state (mode 0 init, 1 tracking, 2 error)
    int m_mode = 0, m_err = 0, m_code = 0, m_wraps = 0;
    int m_pg = 0, m_pov = 0, m_bin = 0, m_step = 0, m_wrap = 0;

    function automatic int bin_of(input int g);
        for (int b = 0; b < 8; b++)
            if (((b ^ (b >> 1)) & 7) == g) return b;
        return -1;
    endfunction

    function automatic int to_gray(input int b);
        return (b ^ (b >> 1)) & 7;
    endfunction

    function automatic int hamming(input int a, input int b);
        int n;
        n = 0;
        for (int i = 0; i < 3; i++) n += ((a ^ b) >> i) & 1;
        return n;
    endfunction

    function automatic logic [OW-1:0] pack_exp();
        logic [2:0] b3;
        logic [7:0] w8;
        logic [1:0] c2, s2;
        b3 = 3'(m_bin); w8 = 8'(m_wraps); c2 = 2'(m_code); s2 = 2'(m_mode);
`ifdef GRAY_MON_WRAP_PULSE_EN
        return {b3, 1'(m_step), w8, 1'(m_err), c2, s2, 1'(m_wrap)};
`else
        return {b3, 1'(m_step), w8, 1'(m_err), c2, s2};
`endif
    endfunction

    function automatic logic [OW-1:0] pack_dut();
`ifdef GRAY_MON_WRAP_PULSE_EN
        return {bus.Bin, bus.Step, bus.WrapCount, bus.Error, bus.ErrCode, bus.State, bus.Wrap};
`else
        return {bus.Bin, bus.Step, bus.WrapCount, bus.Error, bus.ErrCode, bus.State};
`endif
    endfunction

    task automatic model_edge(input int r, input int c, input int g, input int ov);
        int b, pb, code;
        bit legal, wrapped;
        m_step = 0;
        m_wrap = 0;
        if (r != 0) begin
            m_mode = 0; m_err = 0; m_code = 0; m_wraps = 0;
            m_bin = 0; m_pg = 0; m_pov = 0;
        end else begin
            b       = bin_of(g);
            pb      = bin_of(m_pg);
            legal   = (g != m_pg) && (b == (pb + 1) % 8);
            wrapped = legal && (pb == 7);
            m_bin   = b;
            if (c != 0) begin
                m_mode = 0; m_err = 0; m_code = 0; m_wraps = 0;
            end else if (m_mode == 0) begin
                m_mode = 1;
            end else if (m_mode == 1) begin
                code = 0;
                if (g != m_pg && !legal)                  code = (hamming(g, m_pg) > 1) ? 1 : 2;
                else if (ov == 1 && m_pov == 0 && !wrapped) code = 3;
                else if (ov == 0 && m_pov == 1 && g != 0)   code = 3;
                if (code != 0) begin
                    m_mode = 2; m_err = 1; m_code = code;
                end else if (legal) begin
                    m_step = 1;
                    if (wrapped) begin
                        m_wrap = 1;
                        if (m_wraps < 255) m_wraps++;
                    end
                end
            end
            m_pg  = g;
            m_pov = ov;
        end
    endtask

    task automatic cycle(input int r, input int c, input int g, input int ov, input string tag);
        exp_t e;
        @(negedge clk);
        rst            = r[0];
        clr            = c[0];
        bus.GrayIn     = 3'(g);
        bus.OverflowIn = ov[0];
        model_edge(r, c, g, ov);
        e.v   = pack_exp();
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Monitor: one comparison per edge that has a pending expectation
    initial begin
        exp_t e;
        logic [OW-1:0] got;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = pack_dut();
                checks++;
                txn++;
                if (got !== e.v) begin
                    errors++;
                    $display("FAIL %s txn %0d: got %h required %h", e.tag, txn, got, e.v);
                end else begin
                    $display("txn %0d %s ok out=%h", txn, e.tag, got);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq[9];
        int k, g, ov, r;
        rst = 1'b1; clr = 1'b0; bus.GrayIn = '0; bus.OverflowIn = 1'b0;

        cycle(1, 0, 0, 0, "reset");
        cycle(1, 0, 0, 0, "reset");

        seq = '{0, 1, 3, 2, 6, 7, 5, 4, 0};
        for (int i = 0; i < 9; i++) cycle(0, 0, seq[i], (i == 8) ? 1 : 0, "t1_seq");
        cycle(0, 0, 0, 1, "t1_hold");

        cycle(0, 1, 0, 0, "t2_clr");
        cycle(0, 0, 1, 0, "t2_init");
        cycle(0, 0, 2, 0, "t2_multi");
        cycle(0, 0, 3, 0, "t2_frozen");

        cycle(0, 1, 0, 0, "t3_clr");
        cycle(0, 0, 0, 0, "t3_init");
        cycle(0, 0, 0, 0, "t3_hold");
        cycle(0, 0, 4, 0, "t3_single");
        cycle(0, 1, 4, 0, "t3_clr2");

        cycle(0, 1, 3, 0, "t4_clr");
        cycle(0, 0, 3, 0, "t4_init");
        cycle(0, 0, 3, 0, "t4_hold");
        cycle(0, 0, 3, 1, "t4_ovrise");
        cycle(0, 1, 0, 1, "t4_clr2");
        cycle(0, 0, 0, 1, "t4_init2");
        cycle(0, 0, 0, 1, "t4_hold2");
        cycle(0, 0, 0, 0, "t4_ovfall0");
        cycle(0, 0, 0, 0, "t4_hold3");

        cycle(0, 1, 0, 0, "t5_clr");
        cycle(0, 0, 0, 0, "t5_init");
        for (int i = 1; i <= 300 * 8; i++) cycle(0, 0, to_gray(i % 8), 0, "t5_wrap");
        cycle(0, 0, 1, 0, "t5_sat");

        cycle(0, 0, 3, 0, "t6_step");
        cycle(1, 1, 2, 0, "t6_rst");
        cycle(0, 0, 6, 0, "t6_after");

        for (int i = 0; i < 2000; i++) begin
            r  = $urandom_range(0, 99);
            ov = m_pov;
            if ($urandom_range(0, 9) == 0) ov = 1 - m_pov;
            if (r < 2) begin
                cycle(1, 0, 0, 0, "rnd_rst");
            end else if (r < 6) begin
                cycle(0, 1, $urandom_range(0, 7), 0, "rnd_clr");
            end else if (r < 75) begin
                k = (bin_of(m_pg) + 1) % 8;
                g = to_gray(k);
                if (g == 0) ov = $urandom_range(0, 1);
                cycle(0, 0, g, ov, "rnd_step");
            end else if (r < 85) begin
                cycle(0, 0, m_pg, ov, "rnd_hold");
            end else begin
                cycle(0, 0, $urandom_range(0, 7), ov, "rnd_any");
            end
        end

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending %0d required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
